// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Size codes, FSM encoding and byte-count helper.
package lsu_pkg;

    localparam logic [1:0] LSU_SZ_B = 2'b00;
    localparam logic [1:0] LSU_SZ_H = 2'b01;
    localparam logic [1:0] LSU_SZ_W = 2'b10;
    localparam logic [1:0] LSU_SZ_X = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

    function automatic logic [2:0] lsu_nbytes(
        input logic [1:0] sz
    );
        logic [2:0] n;
        n = 3'd4;
        unique case (1'b1)
            (sz == LSU_SZ_B): n = 3'd1;
            (sz == LSU_SZ_H): n = 3'd2;
            (sz == LSU_SZ_W): n = 3'd4;
            default:          n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Execute-side request/response and memory bus
// of the load/store unit.
interface lsu_if;
    logic        iwReqValid;
    logic        owReqReady;
    logic        iwReqWrite;
    logic [1:0]  iwReqSize;
    logic        iwReqSigned;
    logic [31:0] iwReqAddr;
    logic [31:0] iwReqWData;
    logic        owRespValid;
    logic        owRespErr;
    logic [31:0] owRespRData;
    logic [31:0] owMemReadAddr;
    logic [31:0] owMemWriteAddr;
    logic [31:0] owMemWriteData;
    logic [3:0]  owMemWstrb;
    logic [31:0] iwMemReadData;

    modport slave (
        input  iwReqValid, iwReqWrite, iwReqSize,
        input  iwReqSigned, iwReqAddr, iwReqWData,
        input  iwMemReadData,
        output owReqReady, owRespValid, owRespErr,
        output owRespRData, owMemReadAddr,
        output owMemWriteAddr, owMemWriteData,
        output owMemWstrb
    );

    modport master (
        output iwReqValid, iwReqWrite, iwReqSize,
        output iwReqSigned, iwReqAddr, iwReqWData,
        output iwMemReadData,
        input  owReqReady, owRespValid, owRespErr,
        input  owRespRData, owMemReadAddr,
        input  owMemWriteAddr, owMemWriteData,
        input  owMemWstrb
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobe/data shifting
// and load extraction with zero/sign extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [63:0] i_rd64,
    output logic        o_cross,
    output logic [7:0]  o_m8,
    output logic [63:0] o_d64,
    output logic [31:0] o_rdata
);
    logic [2:0]  w_nb;
    logic [2:0]  w_sum;
    logic [4:0]  w_sh;
    logic [7:0]  w_base;
    logic [31:0] w_rd;

    assign w_nb    = lsu_nbytes(i_size);
    assign w_sum   = {1'b0, i_off} + w_nb;
    assign o_cross = (w_sum > 3'd4);
    assign w_sh    = {i_off, 3'b000};

    always_comb begin
        w_base = 8'h0F;
        unique case (1'b1)
            (w_nb == 3'd1): w_base = 8'h01;
            (w_nb == 3'd2): w_base = 8'h03;
            default:        w_base = 8'h0F;
        endcase
    end

    assign o_m8  = w_base << i_off;
    assign o_d64 = {32'b0, i_wdata} << w_sh;
    assign w_rd  = 32'(i_rd64 >> w_sh);

    always_comb begin
        o_rdata = w_rd;
        unique case (1'b1)
            (i_size == LSU_SZ_B):
                o_rdata = {{24{i_signed & w_rd[7]}},
                           w_rd[7:0]};
            (i_size == LSU_SZ_H):
                o_rdata = {{16{i_signed & w_rd[15]}},
                           w_rd[15:0]};
            default:
                o_rdata = w_rd;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: request FSM splitting accesses
// into word-aligned memory cycles with byte strobes.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter bit pSplitMisaligned = 1'b1
) (
    input  logic   iwClk,
    input  logic   iwnRst,
    lsu_if.slave   bus
);
    lsu_state_t  r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_err;
    logic [31:0] r_lo;
    logic        r_ready;
    logic        r_rvalid;
    logic        r_rerr;
    logic [31:0] r_rdata;
    logic [31:0] r_ra;
    logic [31:0] r_wa;
    logic [31:0] r_wd;
    logic [3:0]  r_wstrb;

    logic        w_idle;
    logic        w_accept;
    logic        w_write;
    logic [1:0]  w_size;
    logic        w_signed;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [31:0] w_wa;
    logic [31:0] w_wb;
    logic [63:0] w_rd64;
    logic        w_cross;
    logic [7:0]  w_m8;
    logic [63:0] w_d64;
    logic [31:0] w_ld;
    logic        w_bad;

    // In IDLE the aligner sees the incoming request so the
    // first access can be registered on the accept edge.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = bus.iwReqValid && r_ready;
    assign w_write  = w_idle ? bus.iwReqWrite  : r_write;
    assign w_size   = w_idle ? bus.iwReqSize   : r_size;
    assign w_signed = w_idle ? bus.iwReqSigned : r_signed;
    assign w_addr   = w_idle ? bus.iwReqAddr   : r_addr;
    assign w_wdata  = w_idle ? bus.iwReqWData  : r_wdata;
    assign w_wa     = {w_addr[31:2], 2'b00};
    assign w_wb     = {r_addr[31:2], 2'b00} + 32'd4;
    assign w_rd64   = w_cross ? {bus.iwMemReadData, r_lo}
                              : {32'b0, bus.iwMemReadData};
    assign w_bad    = (w_size == LSU_SZ_X) ||
                      (w_cross && !pSplitMisaligned);

    lsu_align u_align (
        .i_size   (w_size),
        .i_signed (w_signed),
        .i_off    (w_addr[1:0]),
        .i_wdata  (w_wdata),
        .i_rd64   (w_rd64),
        .o_cross  (w_cross),
        .o_m8     (w_m8),
        .o_d64    (w_d64),
        .o_rdata  (w_ld)
    );

    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            r_state  <= ST_IDLE;
            r_write  <= 1'b0;
            r_size   <= LSU_SZ_B;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_lo     <= '0;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_rerr   <= 1'b0;
            r_rdata  <= '0;
            r_ra     <= '0;
            r_wa     <= '0;
            r_wd     <= '0;
            r_wstrb  <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: if (w_accept) begin
                    r_write  <= w_write;
                    r_size   <= w_size;
                    r_signed <= w_signed;
                    r_addr   <= w_addr;
                    r_wdata  <= w_wdata;
                    r_err    <= w_bad;
                    r_ready  <= 1'b0;
                    r_state  <= ST_ACC0;
                    if (!w_bad) begin
                        r_ra    <= w_wa;
                        r_wa    <= w_wa;
                        r_wd    <= w_d64[31:0];
                        r_wstrb <= w_write ? w_m8[3:0] : 4'h0;
                    end
                end
                ST_ACC0: begin
                    if (r_err) begin
                        r_state  <= ST_RESP;
                        r_rvalid <= 1'b1;
                        r_rerr   <= 1'b1;
                        r_rdata  <= '0;
                    end else if (w_cross) begin
                        r_state <= ST_ACC1;
                        r_ra    <= w_wb;
                        r_wa    <= w_wb;
                        r_wd    <= w_d64[63:32];
                        r_wstrb <= r_write ? w_m8[7:4] : 4'h0;
                    end else if (r_write) begin
                        r_wstrb  <= 4'h0;
                        r_state  <= ST_RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= '0;
                    end else begin
                        r_wstrb <= 4'h0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_ACC1: begin
                    r_wstrb <= 4'h0;
                    if (r_write) begin
                        r_state  <= ST_RESP;
                        r_rvalid <= 1'b1;
                        r_rdata  <= '0;
                    end else begin
                        r_lo    <= bus.iwMemReadData;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_state  <= ST_RESP;
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_ld;
                end
                ST_RESP: begin
                    r_state  <= ST_IDLE;
                    r_rvalid <= 1'b0;
                    r_rerr   <= 1'b0;
                    r_ready  <= 1'b1;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.owReqReady     = r_ready;
    assign bus.owRespValid    = r_rvalid;
    assign bus.owRespErr      = r_rerr;
    assign bus.owRespRData    = r_rdata;
    assign bus.owMemReadAddr  = r_ra;
    assign bus.owMemWriteAddr = r_wa;
    assign bus.owMemWriteData = r_wd;
    assign bus.owMemWstrb     = r_wstrb;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: scoreboarded requests
// against a small word memory, plus split-off variant.
module tb_load_store_unit;
    logic iwClk;
    logic iwnRst;

    lsu_if bus ();
    lsu_if bus2 ();

    load_store_unit #(.pSplitMisaligned(1'b1)) u_dut (
        .iwClk  (iwClk),
        .iwnRst (iwnRst),
        .bus    (bus.slave)
    );

    load_store_unit #(.pSplitMisaligned(1'b0)) u_dut2 (
        .iwClk  (iwClk),
        .iwnRst (iwnRst),
        .bus    (bus2.slave)
    );

    initial iwClk = 1'b0;
    always #5 iwClk = ~iwClk;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int n_resp = 0;
    logic strb2_seen = 1'b0;
    logic [31:0] mem [16];
    logic [31:0] tr_ra [1:6];
    logic [31:0] tr_wa [1:6];
    logic [31:0] tr_wd [1:6];
    logic [3:0]  tr_st [1:6];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge iwClk) cyc <= cyc + 1;

    // Memory: data returned the cycle after the address.
    always @(posedge iwClk) begin
        bus.iwMemReadData <= mem[bus.owMemReadAddr[5:2]];
        for (int i = 0; i < 4; i++)
            if (bus.owMemWstrb[i])
                mem[bus.owMemWriteAddr[5:2]][8*i +: 8]
                    <= bus.owMemWriteData[8*i +: 8];
    end

    always @(negedge iwClk) begin
        if (bus2.owMemWstrb != 4'h0) strb2_seen = 1'b1;
        if (bus.owRespValid) begin
            n_resp++;
            if (q.size() == 0) begin
                chk("unexp_resp", 32'd1, 32'd0);
            end else begin
                exp_t x;
                x = q.pop_front();
                chk("err", {31'b0, bus.owRespErr},
                    {31'b0, x.err});
                chk("rdata", bus.owRespRData, x.rd);
                chk("lat", cyc - t0, x.lat);
            end
        end
    end

    task automatic issue(input logic w,
                         input logic [1:0] sz,
                         input logic sg,
                         input logic [31:0] a,
                         input logic [31:0] d,
                         input logic e,
                         input logic [31:0] r,
                         input int lat);
        int n0;
        @(negedge iwClk);
        chk("ready", {31'b0, bus.owReqReady}, 32'd1);
        bus.iwReqValid  = 1'b1;
        bus.iwReqWrite  = w;
        bus.iwReqSize   = sz;
        bus.iwReqSigned = sg;
        bus.iwReqAddr   = a;
        bus.iwReqWData  = d;
        t0 = cyc;
        n0 = n_resp;
        q.push_back('{e, r, lat});
        for (int k = 1; k <= 6; k++) begin
            @(negedge iwClk);
            bus.iwReqValid = 1'b0;
            tr_ra[k] = bus.owMemReadAddr;
            tr_wa[k] = bus.owMemWriteAddr;
            tr_wd[k] = bus.owMemWriteData;
            tr_st[k] = bus.owMemWstrb;
        end
        chk("resp_count", n_resp - n0, 32'd1);
    endtask

    initial begin
        logic got2;
        int n0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        iwnRst = 1'b0;
        bus.iwReqValid   = 1'b0;
        bus.iwReqWrite   = 1'b0;
        bus.iwReqSize    = 2'b00;
        bus.iwReqSigned  = 1'b0;
        bus.iwReqAddr    = '0;
        bus.iwReqWData   = '0;
        bus2.iwReqValid  = 1'b0;
        bus2.iwReqWrite  = 1'b0;
        bus2.iwReqSize   = 2'b00;
        bus2.iwReqSigned = 1'b0;
        bus2.iwReqAddr   = '0;
        bus2.iwReqWData  = '0;
        bus2.iwMemReadData = '0;
        repeat (3) @(negedge iwClk);
        chk("rst_ready", {31'b0, bus.owReqReady}, 32'd1);
        chk("rst_rvalid", {31'b0, bus.owRespValid}, 32'd0);
        chk("rst_rdata", bus.owRespRData, 32'd0);
        chk("rst_wstrb", {28'b0, bus.owMemWstrb}, 32'd0);
        chk("rst_raddr", bus.owMemReadAddr, 32'd0);
        iwnRst = 1'b1;

        issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF,
              0, 32'h0, 2);
        chk("sw_wa", tr_wa[1], 32'h10);
        chk("sw_st", {28'b0, tr_st[1]}, 32'hF);
        chk("sw_wd", tr_wd[1], 32'hDEADBEEF);
        chk("sw_st2", {28'b0, tr_st[2]}, 32'h0);

        issue(1, 2'b00, 0, 32'h13, 32'h000000AB,
              0, 32'h0, 2);
        chk("sb_st", {28'b0, tr_st[1]}, 32'h8);
        chk("sb_wd", {24'b0, tr_wd[1][31:24]}, 32'hAB);
        issue(0, 2'b10, 0, 32'h10, 32'h0,
              0, 32'hABADBEEF, 3);

        issue(1, 2'b01, 0, 32'h12, 32'h00008001,
              0, 32'h0, 2);
        chk("sh_st", {28'b0, tr_st[1]}, 32'hC);
        issue(0, 2'b01, 1, 32'h12, 32'h0,
              0, 32'hFFFF8001, 3);
        issue(0, 2'b01, 0, 32'h12, 32'h0,
              0, 32'h00008001, 3);

        issue(1, 2'b10, 0, 32'h0C, 32'h44332211,
              0, 32'h0, 2);
        issue(1, 2'b10, 0, 32'h10, 32'h88776655,
              0, 32'h0, 2);
        issue(0, 2'b10, 0, 32'h0E, 32'h0,
              0, 32'h66554433, 4);
        chk("xl_ra1", tr_ra[1], 32'h0C);
        chk("xl_ra2", tr_ra[2], 32'h10);
        issue(0, 2'b01, 1, 32'h0F, 32'h0,
              0, 32'h00005544, 4);
        issue(0, 2'b00, 1, 32'h13, 32'h0,
              0, 32'hFFFFFF88, 3);

        issue(1, 2'b10, 0, 32'hFFFFFFFE, 32'h11223344,
              0, 32'h0, 3);
        chk("xs_wa1", tr_wa[1], 32'hFFFFFFFC);
        chk("xs_st1", {28'b0, tr_st[1]}, 32'hC);
        chk("xs_wd1", tr_wd[1], 32'h33440000);
        chk("xs_wa2", tr_wa[2], 32'h00000000);
        chk("xs_st2", {28'b0, tr_st[2]}, 32'h3);
        chk("xs_wd2", tr_wd[2], 32'h00001122);
        issue(0, 2'b10, 0, 32'hFFFFFFFE, 32'h0,
              0, 32'h11223344, 4);

        issue(1, 2'b11, 0, 32'h10, 32'h12345678,
              1, 32'h0, 2);
        chk("sz3_st1", {28'b0, tr_st[1]}, 32'h0);
        chk("sz3_st2", {28'b0, tr_st[2]}, 32'h0);
        issue(0, 2'b10, 0, 32'h10, 32'h0,
              0, 32'h88776655, 3);

        // Split disabled: crossing store is rejected.
        @(negedge iwClk);
        bus2.iwReqValid = 1'b1;
        bus2.iwReqWrite = 1'b1;
        bus2.iwReqSize  = 2'b10;
        bus2.iwReqAddr  = 32'hFFFFFFFE;
        bus2.iwReqWData = 32'h11223344;
        n0 = cyc;
        got2 = 1'b0;
        @(negedge iwClk);
        bus2.iwReqValid = 1'b0;
        for (int k = 1; k <= 8 && !got2; k++) begin
            if (bus2.owRespValid) begin
                got2 = 1'b1;
                chk("ns_err", {31'b0, bus2.owRespErr}, 32'd1);
                chk("ns_rdata", bus2.owRespRData, 32'd0);
                chk("ns_lat", cyc - n0, 32'd2);
            end else begin
                @(negedge iwClk);
            end
        end
        chk("ns_resp", {31'b0, got2}, 32'd1);
        chk("ns_strb", {31'b0, strb2_seen}, 32'd0);

        // Reset during the second access of a crossing load.
        @(negedge iwClk);
        bus.iwReqValid  = 1'b1;
        bus.iwReqWrite  = 1'b0;
        bus.iwReqSize   = 2'b10;
        bus.iwReqSigned = 1'b0;
        bus.iwReqAddr   = 32'h0E;
        n0 = n_resp;
        @(negedge iwClk);
        bus.iwReqValid = 1'b0;
        chk("mr_busy", {31'b0, bus.owReqReady}, 32'd0);
        @(negedge iwClk);
        chk("mr_acc1_ra", bus.owMemReadAddr, 32'h10);
        iwnRst = 1'b0;
        #1;
        chk("mr_rvalid", {31'b0, bus.owRespValid}, 32'd0);
        chk("mr_ra", bus.owMemReadAddr, 32'd0);
        chk("mr_st", {28'b0, bus.owMemWstrb}, 32'd0);
        @(negedge iwClk);
        iwnRst = 1'b1;
        repeat (5) @(negedge iwClk);
        chk("mr_ready", {31'b0, bus.owReqReady}, 32'd1);
        chk("mr_noresp", n_resp - n0, 32'd0);

        issue(0, 2'b10, 0, 32'h0C, 32'h0,
              0, 32'h44332211, 3);

        $display("test done: total=%0d bad=%0d",
                 total, bad);
        $finish;
    end
endmodule
